// File: rtl/meso_sync_arbiter.sv
// Write-domain round-robin arbiter and credit flow controller feeding a
// mesochronous synchronizer with registered {valid, id, data} words.
module meso_sync_arbiter #(
  parameter int unsigned REQUESTERS = 4,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned CREDITS    = 4,
  localparam int unsigned IDW       = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1,
  localparam int unsigned CW        = $clog2(CREDITS + 1),
  localparam int unsigned SW        = 1 + IDW + DATA_SIZE
) (
  input  logic                            wrrst_ni,
  input  logic                            wrclk_i,
  input  logic [REQUESTERS-1:0]           req_i,
  input  logic [REQUESTERS*DATA_SIZE-1:0] data_i,
  output logic [REQUESTERS-1:0]           gnt_o,
  input  logic                            credit_i,
  output logic [SW-1:0]                   sync_d_o,
  output logic [CW-1:0]                   credits_o,
  output logic                            err_o
);

  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]        cred_q, cred_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [DATA_SIZE-1:0] data_q, data_d;

  logic                 found;
  logic [IDW-1:0]       win_id;
  logic                 grant_en;
  logic [DATA_SIZE-1:0] win_data;

  // Round-robin priority search starting at the pointer, wrapping modulo REQUESTERS.
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      idx = (32'(ptr_q) + k) % REQUESTERS;
      if (!found && req_i[IDW'(idx)]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  // Credit from credit_i this cycle does not unblock an empty counter.
  assign grant_en = found && (cred_q != '0) && wrrst_ni;
  assign gnt_o    = grant_en ? (REQUESTERS'(1) << win_id) : '0;
  assign win_data = data_i[32'(win_id)*DATA_SIZE +: DATA_SIZE];

  always_comb begin
    ptr_d   = ptr_q;
    cred_d  = cred_q;
    err_d   = err_q;
    valid_d = grant_en;
    id_d    = id_q;
    data_d  = data_q;

    // id/data hold when idle to keep the synchronizer input quiet.
    if (grant_en) begin
      id_d   = win_id;
      data_d = win_data;
      ptr_d  = (win_id == IDW'(REQUESTERS - 1)) ? '0 : win_id + IDW'(1);
    end

    case ({grant_en, credit_i})
      2'b10: cred_d = cred_q - CW'(1);
      2'b01: begin
        if (cred_q == CW'(CREDITS)) err_d = 1'b1;
        else                        cred_d = cred_q + CW'(1);
      end
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge wrclk_i or negedge wrrst_ni) begin
    if (!wrrst_ni) begin
      ptr_q   <= '0;
      cred_q  <= CW'(CREDITS);
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign sync_d_o  = {valid_q, id_q, data_q};
  assign credits_o = cred_q;
  assign err_o     = err_q;

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge wrclk_i) disable iff (!wrrst_ni) $onehot0(gnt_o));
  a_cred_max:   assert property (@(posedge wrclk_i) disable iff (!wrrst_ni) cred_q <= CW'(CREDITS));
`endif

endmodule

// File: tb/tb_meso_sync_arbiter.sv
// Directed bench for meso_sync_arbiter with a spec-level model checked every cycle.
module tb_meso_sync_arbiter;
  localparam int R   = 4;
  localparam int DW  = 32;
  localparam int C   = 4;
  localparam int IDW = 2;
  localparam int CW  = 3;
  localparam int SW  = 1 + IDW + DW;

  logic            wrrst_ni;
  logic            wrclk_i = 1'b0;
  logic [R-1:0]    req_i;
  logic [R*DW-1:0] data_i;
  logic [R-1:0]    gnt_o;
  logic            credit_i;
  logic [SW-1:0]   sync_d_o;
  logic [CW-1:0]   credits_o;
  logic            err_o;

  meso_sync_arbiter #(.REQUESTERS(R), .DATA_SIZE(DW), .CREDITS(C)) dut (
    .wrrst_ni (wrrst_ni),
    .wrclk_i  (wrclk_i),
    .req_i    (req_i),
    .data_i   (data_i),
    .gnt_o    (gnt_o),
    .credit_i (credit_i),
    .sync_d_o (sync_d_o),
    .credits_o(credits_o),
    .err_o    (err_o)
  );

  always #5 wrclk_i = ~wrclk_i;

  int total = 0;
  int bad   = 0;

  int          m_cred;
  int          m_ptr;
  logic        m_err;
  logic        m_valid;
  int          m_id;
  logic [31:0] m_data;
  logic [R-1:0] dut_gnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred  = C;
    m_ptr   = 0;
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_id    = 0;
    m_data  = '0;
  endtask

  // Winner under the arbitration rules, or -1 when no grant is allowed.
  function automatic int pick();
    if (!wrrst_ni || req_i == '0 || m_cred == 0) return -1;
    for (int k = 0; k < R; k++) begin
      int n;
      n = (m_ptr + k) % R;
      if (req_i[n]) return n;
    end
    return -1;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int g;
    logic [SW-1:0] exp_sync;
    @(negedge wrclk_i);
    g        = pick();
    dut_gnt  = gnt_o;
    exp_sync = {m_valid, IDW'(m_id), m_data};
    chk("gnt",     64'(gnt_o),     (g < 0) ? 64'd0 : (64'd1 << g));
    chk("sync",    64'(sync_d_o),  64'(exp_sync));
    chk("credits", 64'(credits_o), 64'(m_cred));
    chk("err",     64'(err_o),     64'(m_err));
    @(posedge wrclk_i);
    if (!wrrst_ni) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_id    = g;
        m_data  = data_i[g*DW +: DW];
        m_ptr   = (g + 1) % R;
      end else begin
        m_valid = 1'b0;
      end
      if (g >= 0 && !credit_i) m_cred = m_cred - 1;
      else if (g < 0 && credit_i) begin
        if (m_cred == C) m_err = 1'b1;
        else             m_cred = m_cred + 1;
      end
    end
    #1;
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    wrrst_ni = 1'b0;
    req_i    = '0;
    data_i   = '0;
    credit_i = 1'b0;
    dut_gnt  = '0;
    model_reset();
    repeat (2) cycle();
    wrrst_ni = 1'b1;
    cycle();
    chk("rst_sync",    64'(sync_d_o),  64'd0);
    chk("rst_credits", 64'(credits_o), 64'd4);
    chk("rst_err",     64'(err_o),     64'd0);
    chk("rst_gnt",     64'(gnt_o),     64'd0);

    // Credit exhaustion with a single requester
    data_i[31:0] = 32'hA5A5_0001;
    req_i = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("exh_gnt",  64'(dut_gnt),   64'd1);
      chk("exh_cred", 64'(credits_o), 64'(3 - i));
      chk("exh_word", 64'(sync_d_o),  64'({1'b1, 2'd0, 32'hA5A5_0001}));
    end
    cycle();
    chk("exh_stall", 64'(dut_gnt), 64'd0);
    credit_i = 1'b1;
    cycle();
    chk("exh_cr_nogrant", 64'(dut_gnt),   64'd0);
    chk("exh_cr_count",   64'(credits_o), 64'd1);
    credit_i = 1'b0;
    cycle();
    chk("exh_one_more", 64'(dut_gnt),   64'd1);
    chk("exh_cred0",    64'(credits_o), 64'd0);
    cycle();
    chk("exh_stall2", 64'(dut_gnt), 64'd0);
    req_i = '0;

    credit_i = 1'b1;
    repeat (4) cycle();
    credit_i = 1'b0;
    chk("refill", 64'(credits_o), 64'd4);

    // Park the pointer at 0 via a grant to requester 3
    data_i[127:96] = 32'hD000_0003;
    req_i = 4'b1000;
    cycle();
    req_i = '0;

    // Round-robin with every requester pending and a credit each cycle
    data_i   = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hA5A5_0001};
    req_i    = 4'b1111;
    credit_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_gnt",   64'(dut_gnt),        64'd1 << order[i]);
      chk("rr_valid", 64'(sync_d_o[34]),   64'd1);
      chk("rr_id",    64'(sync_d_o[33:32]), 64'(order[i]));
    end
    credit_i = 1'b0;
    req_i    = '0;
    chk("rr_cred", 64'(credits_o), 64'd3);

    // Simultaneous grant and credit
    req_i = 4'b0001;
    repeat (2) cycle();
    chk("sim_cred1", 64'(credits_o), 64'd1);
    req_i    = 4'b0100;
    credit_i = 1'b1;
    cycle();
    chk("sim_gnt2",  64'(dut_gnt),   64'b0100);
    chk("sim_hold1", 64'(credits_o), 64'd1);
    credit_i = 1'b0;
    cycle();
    chk("sim_cred0", 64'(credits_o), 64'd0);
    credit_i = 1'b1;
    cycle();
    chk("sim_zero_nogrant", 64'(dut_gnt),   64'd0);
    chk("sim_zero_cred",    64'(credits_o), 64'd1);
    credit_i = 1'b0;
    cycle();
    chk("sim_next_grant", 64'(dut_gnt), 64'b0100);
    req_i = '0;

    // Overflow
    credit_i = 1'b1;
    repeat (4) cycle();
    chk("ovf_full", 64'(credits_o), 64'd4);
    chk("ovf_noerr", 64'(err_o), 64'd0);
    cycle();
    chk("ovf_sat", 64'(credits_o), 64'd4);
    chk("ovf_err", 64'(err_o), 64'd1);
    credit_i = 1'b0;
    repeat (3) cycle();
    chk("ovf_sticky", 64'(err_o), 64'd1);

    // Reset mid-operation
    data_i[95:64] = 32'h2222_0002;
    req_i = 4'b0100;
    repeat (3) cycle();
    chk("mid_valid", 64'(sync_d_o), 64'({1'b1, 2'd2, 32'h2222_0002}));
    chk("mid_cred",  64'(credits_o), 64'd1);
    req_i    = 4'b1111;
    wrrst_ni = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_sync", 64'(sync_d_o),  64'd0);
    chk("mid_rst_cred", 64'(credits_o), 64'd4);
    chk("mid_rst_gnt",  64'(gnt_o),     64'd0);
    chk("mid_rst_err",  64'(err_o),     64'd0);
    repeat (2) cycle();
    wrrst_ni = 1'b1;
    req_i    = 4'b1010;
    cycle();
    chk("mid_first_gnt", 64'(dut_gnt), 64'b0010);
    req_i = '0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
